addr_entry_issue: RTL and testbench
===================================

ADDR_ENTRY_ISSUE -- requirements
Module: addr_entry_issue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address entry width.
REQ-002 SHALL have parameter ID_W, default 4: request tag width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: credit limit, legal range 1..15; CNT_W = $clog2(MAX_OUTSTANDING+1).
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port fifo_valid, input, 1: upstream address FIFO non-empty.
REQ-007 SHALL have port fifo_addr, input, ADDR_W: head entry address, valid with fifo_valid.
REQ-008 SHALL have port fifo_id, input, ID_W: head entry tag.
REQ-009 SHALL have port fifo_is_store, input, 1: head entry is a store.
REQ-010 SHALL have port fifo_pop, output, 1: dequeue head entry this cycle.
REQ-011 SHALL have ports req_valid output 1, req_ready input 1: memory request handshake.
REQ-012 SHALL have ports req_addr output ADDR_W, req_id output ID_W, req_is_store output 1: request payload.
REQ-013 SHALL have port rsp_valid, input, 1: one request completed, frees one credit.
REQ-014 SHALL have port flush, input, 1: discard held, not-yet-accepted request.
REQ-015 SHALL have ports outstanding output CNT_W (accepted, uncompleted requests) and idle output 1.

Function
REQ-016 SHALL hold at most one request in an output register; req_valid, req_addr, req_id, req_is_store driven directly from registers.
REQ-017 SHALL define used = outstanding + req_valid; pop_allowed = state==RUN & ~flush & (used < MAX_OUTSTANDING).
REQ-018 SHALL assert fifo_pop = fifo_valid & pop_allowed & (~req_valid | req_ready), combinationally.
REQ-019 SHALL on fifo_pop load fifo_addr/fifo_id/fifo_is_store into the output register and set req_valid next cycle (latency 1, back-to-back issue at full throughput).
REQ-020 SHALL hold payload and req_valid stable while req_valid & ~req_ready & ~flush.
REQ-021 SHALL clear req_valid after req_valid & req_ready with no fifo_pop the same cycle.
REQ-022 SHALL update outstanding by +1 on req_valid & req_ready, -1 on rsp_valid, unchanged when both occur.
REQ-023 SHALL not reuse a credit freed by rsp_valid in the same cycle (pop_allowed uses registered outstanding).
REQ-024 SHALL ignore rsp_valid when outstanding==0 (saturate at 0) and flag it by assertion.
REQ-025 SHALL implement FSM RUN, DRAIN: RUN->DRAIN on flush; DRAIN->RUN when outstanding==0 and no flush (rsp_valid that drops outstanding to 0 allows RUN next cycle).
REQ-026 SHALL on flush clear req_valid next cycle; a handshake req_valid & req_ready in the flush cycle still counts as accepted (outstanding +1).
REQ-027 SHALL keep fifo_pop low throughout DRAIN and in the flush cycle; flush in DRAIN keeps DRAIN.
REQ-028 SHALL drive idle = state==RUN & outstanding==0 & ~req_valid.
REQ-029 SHALL assert fifo_pop never high while fifo_valid low, and outstanding never exceeds MAX_OUTSTANDING.

Reset
REQ-030 SHALL on rst force state=RUN, req_valid=0, outstanding=0, fifo_pop=0 combinationally during rst, idle=1 after reset; payload registers need no reset.
REQ-031 SHALL let rst override flush, rsp_valid and any handshake in the same cycle, discarding held and outstanding state.

Verification
REQ-032 Back-to-back: fifo_valid=1 with addrs 0x100,0x104,0x108, req_ready=1, rsp_valid=0 -> req_valid cycles 1-3 with those addrs, outstanding reaches 3, fifo_pop high cycles 0-2.
REQ-033 Credit limit: MAX_OUTSTANDING=4, req_ready=1, no responses -> 4 requests issued, fifo_pop low from then on, outstanding=4; one rsp_valid -> exactly one more issue one cycle later.
REQ-034 Backpressure: req_ready=0 for 5 cycles with entry 0x200/id 3 held -> payload stable, fifo_pop=0, outstanding=0; req_ready=1 -> accepted, outstanding=1.
REQ-035 Flush: held entry 0x300, req_ready=0, outstanding=2, flush=1 -> req_valid=0 next cycle, state DRAIN, no pop until two rsp_valid, then RUN and popping resumes.
REQ-036 Simultaneous: req accept + rsp_valid same cycle at outstanding=2 -> outstanding stays 2; rsp_valid at outstanding=0 -> stays 0, assertion fires.
REQ-037 Reset mid-operation: outstanding=3, req_valid=1, rst=1 one cycle -> outstanding=0, req_valid=0, idle=1 next cycle.

Source files
------------

// File: rtl/addr_entry_issue.sv
// addr_entry_issue
//
// Takes entries from the head of an upstream address FIFO and issues them as
// memory requests through a single output register, limiting the number of
// requests in flight to MAX_OUTSTANDING credits. A flush drops the held
// (not yet accepted) request. The block then sits in DRAIN until every
// accepted request has completed, and only then resumes popping.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fifo_valid/addr/id/
//   fifo_is_store            head entry of the upstream FIFO
//   fifo_pop                 dequeue the head entry this cycle (combinational)
//   req_valid/ready          memory request handshake
//   req_addr/id/is_store     request payload, driven straight from registers
//   rsp_valid                one request completed, returns one credit
//   flush                    discard the held request and drain
//   outstanding              accepted but not yet completed requests
//   idle                     RUN, nothing outstanding, nothing held
module addr_entry_issue #(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_valid,
  input  logic [ADDR_W-1:0] fifo_addr,
  input  logic [ID_W-1:0]   fifo_id,
  input  logic              fifo_is_store,
  output logic              fifo_pop,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [ID_W-1:0]   req_id,
  output logic              req_is_store,
  input  logic              rsp_valid,
  input  logic              flush,
  output logic [CNT_W-1:0]  outstanding,
  output logic              idle
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ID_W-1:0]    id_q;
  logic               store_q;
  logic [CNT_W-1:0]   out_q, out_d;

  logic [CNT_W:0]     used;
  logic               pop_allowed;
  logic               accept;
  logic               rsp_eff;

  // Credits in use count the held request too, so a held-but-unaccepted
  // request can never push outstanding past the limit once accepted.
  // Registered out_q is used, so a credit returned this cycle is only
  // reusable next cycle.
  assign used        = {1'b0, out_q} + {{CNT_W{1'b0}}, req_valid_q};
  assign pop_allowed = (state_q == RUN) && !flush &&
                       (used < (CNT_W + 1)'(MAX_OUTSTANDING));
  assign fifo_pop    = !rst && fifo_valid && pop_allowed &&
                       (!req_valid_q || req_ready);

  assign accept  = req_valid_q && req_ready;
  // A response with nothing outstanding is a protocol error; it is dropped
  // so the counter saturates at zero.
  assign rsp_eff = rsp_valid && (out_q != '0);

  always_comb begin
    out_d = out_q + CNT_W'(accept) - CNT_W'(rsp_eff);
  end

  // Held request: a pop always refills it (pop implies the slot is empty or
  // being accepted); otherwise flush or acceptance empties it.
  always_comb begin
    req_valid_d = req_valid_q;
    if (fifo_pop) begin
      req_valid_d = 1'b1;
    end else if (flush || accept) begin
      req_valid_d = 1'b0;
    end
  end

  // Leaving DRAIN looks at the next outstanding value, so the response that
  // retires the last request lets the block run in the following cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (!flush && (out_d == '0)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      req_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      out_q       <= out_d;
    end
  end

  // Payload needs no reset; it is only meaningful while req_valid is high.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      addr_q  <= fifo_addr;
      id_q    <= fifo_id;
      store_q <= fifo_is_store;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_addr     = addr_q;
  assign req_id       = id_q;
  assign req_is_store = store_q;
  assign outstanding  = out_q;
  assign idle         = (state_q == RUN) && (out_q == '0) && !req_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_pop && !fifo_valid))
        else $error("fifo_pop asserted while fifo_valid is low");
      assert (out_q <= CNT_W'(MAX_OUTSTANDING))
        else $error("outstanding exceeds MAX_OUTSTANDING");
      assert (!(rsp_valid && (out_q == '0)))
        else $warning("rsp_valid with no outstanding request, ignored");
    end
  end

endmodule

// File: tb/tb_addr_entry_issue.sv
// Testbench for addr_entry_issue: a table of directed vectors, hand-written
// sequences for backpressure, flush/drain and reset, then randomized traffic,
// all compared against a transaction-level reference model.
module tb_addr_entry_issue;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int MAXO   = 4;
  localparam int CNT_W  = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              rst, fifo_valid, fifo_is_store, fifo_pop;
  logic [ADDR_W-1:0] fifo_addr, req_addr;
  logic [ID_W-1:0]   fifo_id, req_id;
  logic              req_valid, req_ready, req_is_store;
  logic              rsp_valid, flush, idle;
  logic [CNT_W-1:0]  outstanding;

  always #5 clk = ~clk;

  addr_entry_issue #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_valid(fifo_valid), .fifo_addr(fifo_addr), .fifo_id(fifo_id),
    .fifo_is_store(fifo_is_store), .fifo_pop(fifo_pop),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_id(req_id), .req_is_store(req_is_store),
    .rsp_valid(rsp_valid), .flush(flush),
    .outstanding(outstanding), .idle(idle)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the held request slot, a credit count, a drain flag.
  bit                m_held, m_drain, m_st, m_pop;
  logic [ADDR_W-1:0] m_addr;
  logic [ID_W-1:0]   m_id;
  int                m_out;
  bit                seen_pop;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle with the inputs currently applied: check the
  // combinational pop, advance the model across the edge, check registers.
  task automatic tick();
    int  used, nout;
    bit  acc, rsp_eff;
    #1;
    used  = m_out + (m_held ? 1 : 0);
    m_pop = !rst && fifo_valid && !m_drain && !flush && (used < MAXO) &&
            (!m_held || req_ready);
    seen_pop = fifo_pop;
    chk("fifo_pop", fifo_pop, m_pop);
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_held = 0; m_drain = 0;
    end else begin
      acc     = m_held && req_ready;
      rsp_eff = rsp_valid && (m_out > 0);
      nout    = m_out + (acc ? 1 : 0) - (rsp_eff ? 1 : 0);
      if (m_pop) begin
        m_held = 1; m_addr = fifo_addr; m_id = fifo_id; m_st = fifo_is_store;
      end else if (flush || acc) begin
        m_held = 0;
      end
      if (flush) m_drain = 1;
      else if (m_drain && nout == 0) m_drain = 0;
      m_out = nout;
    end
    #1;
    chk("req_valid", req_valid, m_held);
    chk("outstanding", outstanding, m_out);
    chk("idle", idle, !m_drain && m_out == 0 && !m_held);
    if (m_held) begin
      chk("req_addr", req_addr, m_addr);
      chk("req_id", req_id, m_id);
      chk("req_is_store", req_is_store, m_st);
    end
  endtask

  task automatic drive(input bit fv, input logic [ADDR_W-1:0] a, input bit rdy,
                       input bit rsp, input bit fl);
    rst = 0; fifo_valid = fv; fifo_addr = a; fifo_id = ID_W'(a >> 2);
    fifo_is_store = a[2]; req_ready = rdy; rsp_valid = rsp; flush = fl;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    bit                fv;
    logic [ADDR_W-1:0] addr;
    bit                rdy, rsp, fl;
    bit                e_pop, e_rv;
    logic [ADDR_W-1:0] e_addr;
    int                e_out;
    bit                e_idle;
  } vec_t;

  vec_t tbl[14];

  typedef struct { logic [ADDR_W-1:0] a; logic [ID_W-1:0] id; bit st; } ent_t;
  ent_t q[$];

  initial begin
    // back-to-back issue, then credit limit, then simultaneous accept+rsp
    //          fv addr        rdy rsp fl  pop rv addr        out idle
    tbl[0]  = '{1, 32'h100,    1, 0, 0,   1, 1, 32'h100,    0, 0};
    tbl[1]  = '{1, 32'h104,    1, 0, 0,   1, 1, 32'h104,    1, 0};
    tbl[2]  = '{1, 32'h108,    1, 0, 0,   1, 1, 32'h108,    2, 0};
    tbl[3]  = '{0, 32'h0,      1, 0, 0,   0, 0, 32'h0,      3, 0};
    tbl[4]  = '{1, 32'h10c,    1, 0, 0,   1, 1, 32'h10c,    3, 0};
    tbl[5]  = '{1, 32'h110,    1, 0, 0,   0, 0, 32'h0,      4, 0};
    tbl[6]  = '{1, 32'h110,    1, 0, 0,   0, 0, 32'h0,      4, 0};
    tbl[7]  = '{1, 32'h110,    1, 1, 0,   0, 0, 32'h0,      3, 0};
    tbl[8]  = '{1, 32'h110,    1, 0, 0,   1, 1, 32'h110,    3, 0};
    tbl[9]  = '{0, 32'h0,      0, 1, 0,   0, 1, 32'h110,    2, 0};
    tbl[10] = '{0, 32'h0,      1, 1, 0,   0, 0, 32'h0,      2, 0};
    tbl[11] = '{0, 32'h0,      0, 1, 0,   0, 0, 32'h0,      1, 0};
    tbl[12] = '{0, 32'h0,      0, 1, 0,   0, 0, 32'h0,      0, 1};
    tbl[13] = '{0, 32'h0,      0, 1, 0,   0, 0, 32'h0,      0, 1};

    m_out = 0; m_held = 0; m_drain = 0;
    do_reset();
    do_reset();
    chk("reset_idle", idle, 1);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_req_valid", req_valid, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fv, tbl[i].addr, tbl[i].rdy, tbl[i].rsp, tbl[i].fl);
      tick();
      $display("vec %0d: pop=%0b rv=%0b addr=%0h out=%0d idle=%0b",
               i, seen_pop, req_valid, req_addr, outstanding, idle);
      chk("vec_pop", seen_pop, tbl[i].e_pop);
      chk("vec_rv", req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("vec_addr", req_addr, tbl[i].e_addr);
      chk("vec_out", outstanding, tbl[i].e_out);
      chk("vec_idle", idle, tbl[i].e_idle);
    end

    // Backpressure: entry 0x200 / id 3 held for 5 cycles, then accepted
    do_reset();
    drive(1, 32'h200, 0, 0, 0); fifo_id = 4'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h204, 0, 0, 0);
      tick();
      chk("bp_pop", seen_pop, 0);
      chk("bp_addr", req_addr, 32'h200);
      chk("bp_id", req_id, 3);
      chk("bp_out", outstanding, 0);
    end
    drive(0, '0, 1, 0, 0);
    tick();
    chk("bp_accept_out", outstanding, 1);
    $display("backpressure: out=%0d rv=%0b", outstanding, req_valid);

    // Flush with 0x300 held and two outstanding, drain, then resume
    drive(1, 32'h250, 1, 0, 0); tick();
    drive(1, 32'h300, 1, 0, 0); tick();
    drive(1, 32'h304, 0, 0, 0); tick();
    chk("fl_held_addr", req_addr, 32'h300);
    chk("fl_out", outstanding, 2);
    drive(1, 32'h304, 0, 0, 1); tick();
    chk("fl_pop_in_flush", seen_pop, 0);
    chk("fl_rv_cleared", req_valid, 0);
    drive(1, 32'h304, 1, 0, 0); tick(); chk("drain_pop0", seen_pop, 0);
    drive(1, 32'h304, 1, 0, 0); tick(); chk("drain_pop1", seen_pop, 0);
    drive(1, 32'h304, 1, 1, 0); tick(); chk("drain_pop2", seen_pop, 0);
    drive(1, 32'h304, 1, 1, 0); tick(); chk("drain_pop3", seen_pop, 0);
    chk("drain_idle", idle, 1);
    drive(1, 32'h304, 1, 0, 0); tick(); chk("resume_pop", seen_pop, 1);
    $display("flush/drain: resumed, req_addr=%0h", req_addr);

    // Reset mid-operation with outstanding=3 and a held request
    drive(1, 32'h400, 1, 0, 0); tick();
    drive(1, 32'h404, 1, 0, 0); tick();
    drive(1, 32'h408, 1, 0, 0); tick();
    chk("pre_rst_out", outstanding, 3);
    chk("pre_rst_rv", req_valid, 1);
    drive(1, 32'h40c, 1, 1, 1); rst = 1; tick();
    chk("rst_out", outstanding, 0);
    chk("rst_rv", req_valid, 0);
    chk("rst_idle", idle, 1);
    $display("reset mid-op: out=%0d rv=%0b idle=%0b", outstanding, req_valid, idle);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      while (q.size() < 3) begin
        ent_t e;
        e.a = $urandom; e.id = ID_W'($urandom); e.st = 1'($urandom);
        q.push_back(e);
      end
      rst = ($urandom_range(0, 299) == 0);
      fifo_valid = ($urandom_range(0, 3) != 0);
      fifo_addr = q[0].a; fifo_id = q[0].id; fifo_is_store = q[0].st;
      req_ready = ($urandom_range(0, 2) != 0);
      rsp_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 39) == 0);
      tick();
      if (m_pop) void'(q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
